paralelo_serie_tx: RTL and testbench
====================================

# paralelo_serie_tx

Byte-to-serial transmitter at the upstream end of the PHY link; it feeds the serial-to-parallel receiver. Parallel bytes are accepted through a valid/ready handshake into a small FIFO and shifted out MSB-first, one bit per `clk_8f` cycle. The receiver needs a comma preamble to lock, so the block sends a fixed run of 0xBC comma bytes after reset. After that it sends FIFO data when the FIFO holds a byte and 0xBC idle fill when it is empty.

## Interface
- `FIFO_DEPTH`, default 4: number of byte entries in the input FIFO; power of two, ≥2.
- `COMMA`, default 8'hBC: alignment/idle byte.
- `PREAMBLE_COMMAS`, default 4: number of COMMA bytes sent after reset before any data byte.

- `clk_8f`  in  1  bit clock; the only clock. One serial bit per rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `data_in`  in  8  byte to transmit.
- `valid_in`  in  1  `data_in` is valid.
- `ready_out`  out  1  FIFO can accept a byte. Combinational: `!reset && fifo_count < FIFO_DEPTH`.
- `data_out`  out  1  serial bit, registered.
- `byte_strobe`  out  1  registered; high in the cycle `data_out` carries bit 7 of a byte.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- `comma_collision`  out  1  registered one-cycle pulse; an accepted byte equalled `COMMA`.

## Operation
- Internal state:
  - `shift[7:0]`, `bit_cnt[2:0]`
  - FIFO: read/write pointers plus count
  - `preamble_cnt`
  - state ∈ {PREAMBLE, RUN}
- Reset (edge with `reset`=1):
  - `data_out`, `byte_strobe`, `comma_collision` = 0.
  - FIFO emptied; `fifo_count` = 0.
  - `bit_cnt` = 7, `shift` = COMMA, `preamble_cnt` = 1, state = PREAMBLE.
  - Any FIFO contents present at reset, including mid-byte, are discarded.
- Every non-reset edge:
  - `data_out` <= `shift[bit_cnt]`.
  - `byte_strobe` <= (`bit_cnt` == 7).
  - If `bit_cnt` != 0: `bit_cnt` decrements.
  - If `bit_cnt` == 0 (byte boundary): `bit_cnt` <= 7 and `shift` loads the next byte, chosen as follows:
    - PREAMBLE, `preamble_cnt` < `PREAMBLE_COMMAS`: load COMMA; `preamble_cnt`++.
    - PREAMBLE, `preamble_cnt` == `PREAMBLE_COMMAS`: state <= RUN, then apply the RUN rule below on the same edge.
    - RUN, FIFO non-empty: load the FIFO head and pop it.
    - RUN, FIFO empty: load COMMA (idle fill).
- Push: on an edge where `valid_in && ready_out`, `data_in` is written at the tail.
  - Pushes are allowed during PREAMBLE; bytes queue until RUN.
  - `comma_collision` <= (`data_in` == `COMMA`) on that edge, else 0.
  - A 0xBC data byte is still transmitted; the receiver will discard it. The pulse only reports this.
- Simultaneous push and pop: both take effect; `fifo_count` is unchanged.
  - When full, `ready_out` = 0 even if a pop occurs on the same edge. There is no pass-through.
- No bypass: a byte pushed into an empty FIFO on a boundary edge is not loaded that edge. Idle COMMA is loaded, and the byte goes out at the next boundary.
- Bit order is MSB first (bit 7 down to bit 0), matching the receiver's fill order.
- The FIFO pointers wrap modulo `FIFO_DEPTH`. `fifo_count` never exceeds `FIFO_DEPTH` and never underflows, because a pop requires count > 0.

## Timing
- Edges are numbered 1, 2, … after the first edge with `reset`=0.
- Byte n (n ≥ 1) appears on `data_out` after edges 8(n−1)+1 … 8n.
- `byte_strobe` is high after edges 1, 9, 17, …
- Bytes 1…`PREAMBLE_COMMAS` are COMMA. The COMMA pattern 1,0,1,1,1,1,0,0 appears after edges 1–8.
- With the defaults, the first possible data bit appears after edge 33.
- Push-to-first-bit latency in RUN with an empty FIFO is 1–8 cycles to the next boundary, plus 1 cycle for the registered output. The minimum is 2 cycles, for a push on the edge before the boundary.
- Throughput: one byte per 8 cycles; sustained `valid_in` stalls once the FIFO is full.
- Raising `reset` mid-byte truncates that byte. `data_out` is 0 from the next edge, and the preamble restarts in full after release.

## Test plan
- Reset release, `valid_in`=0 for 64 cycles:
  - `data_out` repeats 10111100 eight times.
  - `byte_strobe` is high after edges 1, 9, …, 57.
  - `ready_out` = 1 and `fifo_count` = 0.
- Push 0xA5 at edge 5, during the preamble:
  - Bits after edges 33–40 = 10100101.
  - Bytes 6 onward are COMMA.
  - `fifo_count` = 1 from edge 5 to edge 32.
- Push 0x01, 0x02, 0x03, 0x04, 0x05 on consecutive edges while in RUN:
  - `ready_out` drops after the 4th push; 0x05 is held off.
  - 0x05 is accepted on the edge after the next boundary pop.
  - Bytes go out in order 01, 02, 03, 04, 05, followed by COMMA.
- Push 0xBC while in RUN:
  - `comma_collision` = 1 for exactly one cycle after the push edge.
  - The byte is transmitted as 10111100.
- Assert `reset` at bit 3 of data byte 0x3C with 2 bytes queued:
  - From the next edge, `data_out` = 0 and `fifo_count` = 0.
  - After release: full 4-COMMA preamble, then idle COMMA only; the queued bytes are never sent.
- Push 0x7E exactly on a boundary edge with the FIFO empty:
  - A COMMA is sent first.
  - 0x7E appears 8 cycles later.
  - `fifo_count` goes 1 → 0 at the following boundary.

Source files
------------

// File: rtl/paralelo_serie_tx.sv
// Byte-to-serial PHY transmitter: valid/ready byte FIFO, MSB-first shifter,
// COMMA preamble after reset and COMMA idle fill when the FIFO is empty.
module paralelo_serie_tx #(
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter logic [7:0]  COMMA           = 8'hBC,
    parameter int unsigned PREAMBLE_COMMAS = 4
) (
    input  logic                          clk_8f,
    input  logic                          reset,
    input  logic [7:0]                    data_in,
    input  logic                          valid_in,
    output logic                          ready_out,
    output logic                          data_out,
    output logic                          byte_strobe,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          comma_collision
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned PRE_W = $clog2(PREAMBLE_COMMAS + 1) + 1;

    typedef enum logic {
        ST_PREAMBLE = 1'b0,
        ST_RUN      = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [7:0]         shift_q, shift_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [PRE_W-1:0]   pre_cnt_q, pre_cnt_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               data_out_q, data_out_d;
    logic               strobe_q, strobe_d;
    logic               coll_q, coll_d;
    logic [7:0]         mem_q [FIFO_DEPTH];

    logic               push_c;
    logic               pop_c;
    logic               run_load_c;

    // Full FIFO refuses even when a pop happens on the same edge.
    assign ready_out = !reset && (count_q < CNT_W'(FIFO_DEPTH));
    assign push_c    = valid_in && ready_out;

    assign data_out        = data_out_q;
    assign byte_strobe     = strobe_q;
    assign fifo_count      = count_q;
    assign comma_collision = coll_q;

    // Next-state: bit serialisation, byte selection at boundaries, FIFO bookkeeping.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        pre_cnt_d  = pre_cnt_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        pop_c      = 1'b0;
        run_load_c = 1'b0;
        data_out_d = shift_q[bit_cnt_q];
        strobe_d   = (bit_cnt_q == 3'd7);
        coll_d     = push_c && (data_in == COMMA);

        if (bit_cnt_q != 3'd0) begin
            bit_cnt_d = bit_cnt_q - 3'd1;
        end else begin
            bit_cnt_d = 3'd7;
            case (state_q)
                ST_PREAMBLE: begin
                    if (pre_cnt_q < PRE_W'(PREAMBLE_COMMAS)) begin
                        shift_d   = COMMA;
                        pre_cnt_d = pre_cnt_q + PRE_W'(1);
                    end else begin
                        state_d    = ST_RUN;
                        run_load_c = 1'b1;
                    end
                end
                ST_RUN: begin
                    run_load_c = 1'b1;
                end
                default: begin
                    state_d = ST_PREAMBLE;
                end
            endcase

            // No bypass: only bytes already resident before this edge can be loaded.
            if (run_load_c) begin
                if (count_q != CNT_W'(0)) begin
                    shift_d = mem_q[rd_ptr_q];
                    pop_c   = 1'b1;
                end else begin
                    shift_d = COMMA;
                end
            end
        end

        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end

        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_8f) begin
        if (reset) begin
            state_q    <= ST_PREAMBLE;
            shift_q    <= COMMA;
            bit_cnt_q  <= 3'd7;
            pre_cnt_q  <= PRE_W'(1);
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            data_out_q <= 1'b0;
            strobe_q   <= 1'b0;
            coll_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            pre_cnt_q  <= pre_cnt_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            data_out_q <= data_out_d;
            strobe_q   <= strobe_d;
            coll_q     <= coll_d;
        end
    end

    // FIFO storage; contents are don't-care while the count says empty.
    always_ff @(posedge clk_8f) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

endmodule

// File: tb/tb_paralelo_serie_tx.sv
// Bench for paralelo_serie_tx: queue/arithmetic reference model checked every
// cycle, plus directed scenarios with hand-computed serial byte expectations.
module tb_paralelo_serie_tx;

    localparam int unsigned DEPTH = 4;
    localparam logic [7:0]  CMA   = 8'hBC;
    localparam int unsigned PRE   = 4;
    localparam int          NREC  = 256;

    logic       clk_8f;
    logic       reset;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready_out;
    logic       data_out;
    logic       byte_strobe;
    logic [2:0] fifo_count;
    logic       comma_collision;

    int checks   = 0;
    int failures = 0;

    paralelo_serie_tx #(
        .FIFO_DEPTH      (DEPTH),
        .COMMA           (CMA),
        .PREAMBLE_COMMAS (PRE)
    ) dut (
        .clk_8f          (clk_8f),
        .reset           (reset),
        .data_in         (data_in),
        .valid_in        (valid_in),
        .ready_out       (ready_out),
        .data_out        (data_out),
        .byte_strobe     (byte_strobe),
        .fifo_count      (fifo_count),
        .comma_collision (comma_collision)
    );

    initial clk_8f = 1'b0;
    always #5 clk_8f = ~clk_8f;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: edge e (1-based after release) carries bit 7-((e-1)%8) of the
    // current byte; at every 8th edge the next byte is chosen from preamble/queue/idle.
    logic        m_on = 1'b0;
    logic        m_rst;
    int          m_e;
    logic [7:0]  m_cur;
    logic        m_data, m_strobe, m_coll;
    logic [7:0]  m_q[$];
    int          m_push_edges[$];
    int          m_pos;
    bit          m_can_push;

    always @(posedge clk_8f) begin
        if (reset) begin
            m_on     = 1'b1;
            m_rst    = 1'b1;
            m_e      = 0;
            m_cur    = CMA;
            m_data   = 1'b0;
            m_strobe = 1'b0;
            m_coll   = 1'b0;
            m_q.delete();
            m_push_edges.delete();
        end else if (m_on) begin
            m_rst      = 1'b0;
            m_e        = m_e + 1;
            m_pos      = 7 - ((m_e - 1) % 8);
            m_data     = m_cur[m_pos];
            m_strobe   = (m_pos == 7);
            m_can_push = valid_in && (m_q.size() < DEPTH);
            if (m_pos == 0) begin
                if ((m_e / 8) + 1 <= PRE)   m_cur = CMA;
                else if (m_q.size() > 0)    m_cur = m_q.pop_front();
                else                        m_cur = CMA;
            end
            m_coll = 1'b0;
            if (m_can_push) begin
                m_q.push_back(data_in);
                m_coll = (data_in == CMA);
                m_push_edges.push_back(m_e);
            end
        end
    end

    // Per-cycle compare plus recording of DUT outputs indexed by edge number.
    logic       rec_data  [NREC];
    logic       rec_strb  [NREC];
    logic       rec_coll  [NREC];
    logic       rec_rdy   [NREC];
    logic [2:0] rec_cnt   [NREC];
    logic [7:0] rx[$];
    logic [7:0] rx_acc;

    always @(posedge clk_8f) begin
        #1;
        if (m_on) begin
            chk("data_out",        32'(data_out),        32'(m_data));
            chk("byte_strobe",     32'(byte_strobe),     32'(m_strobe));
            chk("comma_collision", 32'(comma_collision), 32'(m_coll));
            chk("fifo_count",      32'(fifo_count),      32'(m_q.size()));
            chk("ready_out",       32'(ready_out),       32'(!reset && (m_q.size() < DEPTH)));
            if (m_rst) begin
                rx.delete();
                rx_acc = 8'h00;
            end else begin
                if (m_e < NREC) begin
                    rec_data[m_e] = data_out;
                    rec_strb[m_e] = byte_strobe;
                    rec_coll[m_e] = comma_collision;
                    rec_rdy[m_e]  = ready_out;
                    rec_cnt[m_e]  = fifo_count;
                end
                rx_acc = {rx_acc[6:0], data_out};
                if (m_e % 8 == 0) rx.push_back(rx_acc);
            end
        end
    end

    function automatic logic [7:0] rx_byte(input int i);
        return (rx.size() > i) ? rx[i] : 8'hxx;
    endfunction

    function automatic int push_edge(input int i);
        return (m_push_edges.size() > i) ? m_push_edges[i] : -1;
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_8f);
    endtask

    // Leaves the bench at the negedge just before edge 1.
    task automatic do_reset();
        @(negedge clk_8f);
        reset = 1'b1;
        cycles(2);
        reset = 1'b0;
    endtask

    // Holds valid until accepted; returns at the negedge after the accepting edge.
    task automatic push_byte(input logic [7:0] b);
        int t;
        t        = 0;
        data_in  = b;
        valid_in = 1'b1;
        while (!ready_out && t < 40) begin
            @(negedge clk_8f);
            t++;
        end
        if (!ready_out) chk("push_timeout", 32'(b), 32'hFFFF_FFFF);
        @(negedge clk_8f);
        valid_in = 1'b0;
    endtask

    int nstrb;

    initial begin
        reset    = 1'b1;
        valid_in = 1'b0;
        data_in  = 8'h00;

        // Idle after reset: eight COMMAs, strobe every 8 edges.
        do_reset();
        cycles(64);
        for (int i = 0; i < 8; i++) chk("idle_byte", 32'(rx_byte(i)), 32'h0000_00BC);
        nstrb = 0;
        for (int e = 1; e <= 64; e++) nstrb += int'(rec_strb[e]);
        chk("idle_strobe_count", 32'(nstrb), 32'd8);
        chk("idle_strobe_57", 32'(rec_strb[57]), 32'd1);
        chk("first_bits", 32'({rec_data[1], rec_data[2], rec_data[3], rec_data[4],
                               rec_data[5], rec_data[6], rec_data[7], rec_data[8]}), 32'h0000_00BC);

        // Push during preamble: queued until byte 5.
        do_reset();
        cycles(4);
        push_byte(8'hA5);
        cycles(51);
        chk("pre_push_edge", 32'(push_edge(0)), 32'd5);
        chk("pre_cnt_e4",  32'(rec_cnt[4]),  32'd0);
        chk("pre_cnt_e5",  32'(rec_cnt[5]),  32'd1);
        chk("pre_cnt_e31", 32'(rec_cnt[31]), 32'd1);
        chk("pre_cnt_e32", 32'(rec_cnt[32]), 32'd0);
        chk("pre_bit_e33", 32'(rec_data[33]), 32'd1);
        chk("pre_bit_e34", 32'(rec_data[34]), 32'd0);
        chk("pre_byte4", 32'(rx_byte(3)), 32'h0000_00BC);
        chk("pre_byte5", 32'(rx_byte(4)), 32'h0000_00A5);
        chk("pre_byte6", 32'(rx_byte(5)), 32'h0000_00BC);
        chk("pre_byte7", 32'(rx_byte(6)), 32'h0000_00BC);

        // Five pushes in RUN: fifth stalls until the boundary pop at edge 40.
        do_reset();
        cycles(33);
        for (int i = 1; i <= 5; i++) push_byte(8'(i));
        cycles(48);
        chk("burst_push4_edge", 32'(push_edge(3)), 32'd37);
        chk("burst_push5_edge", 32'(push_edge(4)), 32'd41);
        chk("burst_rdy_e37", 32'(rec_rdy[37]), 32'd0);
        chk("burst_rdy_e39", 32'(rec_rdy[39]), 32'd0);
        chk("burst_rdy_e40", 32'(rec_rdy[40]), 32'd1);
        for (int i = 0; i < 5; i++) chk("burst_byte", 32'(rx_byte(5 + i)), 32'(i + 1));
        chk("burst_tail", 32'(rx_byte(10)), 32'h0000_00BC);

        // COMMA as data: one-cycle collision pulse, byte still sent.
        do_reset();
        cycles(33);
        push_byte(8'hBC);
        cycles(16);
        chk("coll_e33", 32'(rec_coll[33]), 32'd0);
        chk("coll_e34", 32'(rec_coll[34]), 32'd1);
        chk("coll_e35", 32'(rec_coll[35]), 32'd0);
        chk("coll_byte6", 32'(rx_byte(5)), 32'h0000_00BC);

        // Reset in the middle of 0x3C with two bytes queued.
        do_reset();
        cycles(33);
        push_byte(8'h3C);
        push_byte(8'h11);
        push_byte(8'h22);
        cycles(8);
        chk("mid_cnt_before", 32'(fifo_count), 32'd2);
        chk("mid_bit4", 32'(data_out), 32'd1);
        reset = 1'b1;
        @(negedge clk_8f);
        chk("mid_data_after", 32'(data_out), 32'd0);
        chk("mid_cnt_after", 32'(fifo_count), 32'd0);
        chk("mid_ready_in_reset", 32'(ready_out), 32'd0);
        reset = 1'b0;
        cycles(80);
        for (int i = 0; i < 10; i++) chk("mid_after_byte", 32'(rx_byte(i)), 32'h0000_00BC);

        // Push exactly on boundary edge 40 into an empty FIFO: no bypass.
        do_reset();
        cycles(39);
        push_byte(8'h7E);
        cycles(20);
        chk("bnd_push_edge", 32'(push_edge(0)), 32'd40);
        chk("bnd_cnt_e39", 32'(rec_cnt[39]), 32'd0);
        chk("bnd_cnt_e40", 32'(rec_cnt[40]), 32'd1);
        chk("bnd_cnt_e47", 32'(rec_cnt[47]), 32'd1);
        chk("bnd_cnt_e48", 32'(rec_cnt[48]), 32'd0);
        chk("bnd_byte6", 32'(rx_byte(5)), 32'h0000_00BC);
        chk("bnd_byte7", 32'(rx_byte(6)), 32'h0000_007E);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

endmodule
